load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the execute stage and the word-wide synchronous data memory. The memory only does full-word reads and writes, addressed by byte address with the two LSBs ignored. This block turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into memory strobes:
- loads get lane extraction and sign/zero extension;
- sub-word stores become a read-modify-write;
- misaligned or illegal requests are flagged instead of issued.

## Interface
- W, 32, data width (fixed at 32 for RV32I)
- D, 8, byte-address width; must match the data memory's D
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  synchronous reset, active-low (0 = reset)
- i_valid  in  1  request present
- o_ready  out  1  block can accept a request this cycle
- i_is_store  in  1  1 = store, 0 = load
- i_funct3  in  3  RV32I funct3 of the load/store
- i_addr  in  D  byte address
- i_wdata  in  W  store data (rs2)
- o_valid  out  1  one-cycle completion pulse
- o_rdata  out  W  extended load result (0 for stores and faults)
- o_fault  out  1  valid with o_valid; request was misaligned or had an illegal funct3
- o_mem_addr  out  D  memory byte address
- o_mem_wdata  out  W  memory write data
- o_mem_read  out  1  memory read strobe
- o_mem_write  out  1  memory write strobe
- i_mem_rdata  in  W  memory read data, valid one cycle after the o_mem_read cycle

## Operation
- **Request latch:** a request is accepted when i_valid & o_ready. On acceptance, latch addr, wdata, funct3 and is_store.
- **States:**
  - IDLE: o_ready=1.
  - On accept: fault → RESP; SW → WRITE; any load, SB or SH → READ.
  - READ: o_mem_read=1. Next state is EXTRACT for a load, MERGE for a store.
  - EXTRACT: register the extended lane of i_mem_rdata into o_rdata → RESP.
  - MERGE: o_mem_write=1. o_mem_wdata = i_mem_rdata with the target lane replaced, computed combinationally → RESP.
  - WRITE: o_mem_write=1, o_mem_wdata = latched wdata → RESP.
  - RESP: o_valid=1 → IDLE.
- **Memory-side outputs:** combinational from state and latched request. o_mem_addr = latched addr in READ, MERGE and WRITE, otherwise 0. Strobes are 0 in all other states.
- **Lanes (little-endian):**
  - byte k = addr[1:0] selects bits [8k+7:8k];
  - halfword h = addr[1] selects bits [16h+15:16h].
- **Extension:** LB/LH sign-extend to W; LBU/LHU zero-extend; LW passes the word through.
- **Store data:** SB writes i_wdata[7:0]; SH writes i_wdata[15:0]. Other bytes of the word are preserved.
- **Fault conditions:**
  - LH/LHU/SH with addr[0]=1;
  - LW/SW with addr[1:0]≠0;
  - load funct3 ∈ {011,110,111};
  - store funct3 > 010.
- **Fault response:** no memory strobe at all; o_rdata=0, o_fault=1 in RESP.
- **No backpressure:** o_valid is a single-cycle pulse and the consumer must capture it. No new request is accepted until back in IDLE.
- **Reset:**
  - While i_reset=0, o_ready, o_mem_read and o_mem_write are forced 0 combinationally, so a write in flight is dropped.
  - State → IDLE; o_valid=0, o_rdata=0, o_fault=0, latched regs=0.

## Timing
- Cycle 0 = accept cycle.
- Latency to o_valid:
  - fault: cycle 1
  - SW: cycle 2
  - load: cycle 3
  - SB/SH: cycle 3
- Throughput: one request per latency+1 cycles (IDLE is re-entered after RESP).
- i_mem_rdata is sampled only in EXTRACT and MERGE, i.e. one cycle after READ.
- o_rdata and o_fault are registered, update on entry to RESP, and hold until the next RESP or reset.
- i_valid while o_ready=0 is ignored; the request must be held by the producer.

## Structure
- Shared definitions package/header `core_defs`:
  - funct3 encodings (LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010);
  - `NOP;
  - LSU state encodings.
- One combinational sub-module, `lsu_align`:
  - inputs: word, addr[1:0], funct3, wdata;
  - outputs: extended load value, merged store word, fault flag.
  - Reused by the bench as a reference model.
- FSM and latches stay in load_store_unit.

## Test plan
- Preload word 0x10 = 0x8899AABB; LB addr 0x11 → o_mem_read in cycle 1, o_valid cycle 3, o_rdata=0xFFFFFFAA, o_fault=0.
- Same word; LHU addr 0x12 → o_rdata=0x00008899. LH addr 0x12 → 0xFFFF8899. LW addr 0x10 → 0x8899AABB.
- SB addr 0x13 wdata 0x12345655 → read cycle 1, write cycle 2 with o_mem_wdata=0x5599AABB; subsequent LW 0x10 returns 0x5599AABB.
- SW addr 0x14 wdata 0xDEADBEEF → o_mem_write only in cycle 1, o_valid cycle 2, no read strobe.
- LW addr 0x12, and separately SH addr 0x11 → o_valid cycle 1 with o_fault=1, o_rdata=0, zero memory strobes. Load funct3=011 → same.
- Assert i_reset=0 during MERGE of an SH → o_mem_write=0 that cycle, memory word unchanged, o_valid never pulses, o_ready=1 the cycle after reset releases.

Source files
------------

// File: rtl/core_defs.sv
`default_nettype none
// ============================================================================
// Package      : core_defs
// Description  : Shared definitions for the load/store path: RV32I funct3
//                encodings, the canonical NOP, LSU state encodings and the
//                request-legality helper used at accept time and in lsu_align.
// Revision     : 1.0 - initial release
// ============================================================================
package core_defs;

    // RV32I load funct3 encodings
    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    // RV32I store funct3 encodings
    localparam logic [2:0] c_F3_SB  = 3'b000;
    localparam logic [2:0] c_F3_SH  = 3'b001;
    localparam logic [2:0] c_F3_SW  = 3'b010;

    // Canonical RV32I NOP (addi x0, x0, 0)
    localparam logic [31:0] c_NOP   = 32'h0000_0013;

    // LSU state encodings
    localparam int          c_ST_W       = 3;
    localparam logic [2:0]  c_ST_IDLE    = 3'd0;
    localparam logic [2:0]  c_ST_READ    = 3'd1;
    localparam logic [2:0]  c_ST_EXTRACT = 3'd2;
    localparam logic [2:0]  c_ST_MERGE   = 3'd3;
    localparam logic [2:0]  c_ST_WRITE   = 3'd4;
    localparam logic [2:0]  c_ST_RESP    = 3'd5;

    // A request faults on an unknown funct3 or when its address is not
    // naturally aligned to the access size (funct3[1:0] encodes the size).
    function automatic logic lsu_fault(input logic       is_store,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        if (is_store) begin
            illegal = (funct3 > c_F3_SW);
        end else begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = |addr_lo;
            default: misaligned = 1'b0;
        endcase
        return illegal | misaligned;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module       : lsu_align
// Description  : Purely combinational lane logic for the load/store unit.
//                Extracts and extends the addressed lane of a memory word for
//                loads, splices store data into a memory word for sub-word
//                stores, and flags misaligned/illegal requests.
// Ports        : i_word       - memory word (little-endian lanes)
//                i_addr_lo    - byte address bits [1:0]
//                i_funct3     - RV32I funct3
//                i_is_store   - 1 = store, 0 = load
//                i_wdata      - store data (rs2)
//                o_load_data  - extended load value
//                o_store_word - i_word with the target lane replaced
//                o_fault      - misaligned or illegal request
// Revision     : 1.0 - initial release
// ============================================================================
module lsu_align
    import core_defs::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    input  logic        i_is_store,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word,
    output logic        o_fault
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection
    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    end

    // Load extension
    always_comb begin
        o_load_data = '0;
        case (i_funct3)
            c_F3_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
            c_F3_LH:  o_load_data = {{16{w_half[15]}}, w_half};
            c_F3_LW:  o_load_data = i_word;
            c_F3_LBU: o_load_data = {24'd0, w_byte};
            c_F3_LHU: o_load_data = {16'd0, w_half};
            default:  o_load_data = '0;
        endcase
    end

    // Store merge: untouched lanes keep the word read from memory
    always_comb begin
        o_store_word = i_word;
        case (i_funct3)
            c_F3_SB: begin
                case (i_addr_lo)
                    2'd0:    o_store_word[7:0]   = i_wdata[7:0];
                    2'd1:    o_store_word[15:8]  = i_wdata[7:0];
                    2'd2:    o_store_word[23:16] = i_wdata[7:0];
                    default: o_store_word[31:24] = i_wdata[7:0];
                endcase
            end
            c_F3_SH: begin
                if (i_addr_lo[1]) begin
                    o_store_word[31:16] = i_wdata[15:0];
                end else begin
                    o_store_word[15:0]  = i_wdata[15:0];
                end
            end
            default: o_store_word = i_wdata;
        endcase
    end

    assign o_fault = lsu_fault(i_is_store, i_funct3, i_addr_lo);

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module       : load_store_unit
// Description  : Converts RV32I loads/stores into word-wide memory strobes.
//                Sub-word stores are performed as read-modify-write; faults
//                are reported without touching memory.
// Ports        : i_clk, i_reset (sync, active-low)
//                i_valid/o_ready        - request handshake
//                i_is_store, i_funct3, i_addr, i_wdata - request fields
//                o_valid, o_rdata, o_fault - one-cycle completion
//                o_mem_addr, o_mem_wdata, o_mem_read, o_mem_write,
//                i_mem_rdata             - synchronous data memory port
// Revision     : 1.0 - initial release
// ============================================================================
module load_store_unit
    import core_defs::*;
#(
    parameter int W = 32,
    parameter int D = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_is_store,
    input  logic [2:0]   i_funct3,
    input  logic [D-1:0] i_addr,
    input  logic [W-1:0] i_wdata,
    output logic         o_valid,
    output logic [W-1:0] o_rdata,
    output logic         o_fault,
    output logic [D-1:0] o_mem_addr,
    output logic [W-1:0] o_mem_wdata,
    output logic         o_mem_read,
    output logic         o_mem_write,
    input  logic [W-1:0] i_mem_rdata
);

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_state_next;

    logic [D-1:0] r_addr;
    logic [W-1:0] r_wdata;
    logic [2:0]   r_funct3;
    logic         r_is_store;
    logic [W-1:0] r_rdata;
    logic         r_fault;

    logic         w_accept;
    logic         w_req_fault;
    logic [W-1:0] w_load_data;
    logic [W-1:0] w_merged;
    logic         w_unused_fault;

    assign w_accept    = i_valid & o_ready;
    // Legality is judged on the live request so a fault skips memory entirely
    assign w_req_fault = lsu_fault(i_is_store, i_funct3, i_addr[1:0]);

    // Lane logic works on the latched request and the returning memory word
    lsu_align u_align (
        .i_word       (i_mem_rdata),
        .i_addr_lo    (r_addr[1:0]),
        .i_funct3     (r_funct3),
        .i_is_store   (r_is_store),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_merged),
        .o_fault      (w_unused_fault)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (w_req_fault) begin
                        w_state_next = c_ST_RESP;
                    end else if (i_is_store && (i_funct3 == c_F3_SW)) begin
                        w_state_next = c_ST_WRITE;
                    end else begin
                        w_state_next = c_ST_READ;
                    end
                end
            end
            c_ST_READ:    w_state_next = r_is_store ? c_ST_MERGE : c_ST_EXTRACT;
            c_ST_EXTRACT: w_state_next = c_ST_RESP;
            c_ST_MERGE:   w_state_next = c_ST_RESP;
            c_ST_WRITE:   w_state_next = c_ST_RESP;
            c_ST_RESP:    w_state_next = c_ST_IDLE;
            default:      w_state_next = c_ST_IDLE;
        endcase
    end

    // Output logic; handshake, strobes and completion are masked while in
    // reset so an in-flight write never reaches memory.
    always_comb begin
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        case (r_state)
            c_ST_IDLE: o_ready = i_reset;
            c_ST_READ: begin
                o_mem_read = i_reset;
                o_mem_addr = r_addr;
            end
            c_ST_MERGE: begin
                o_mem_write = i_reset;
                o_mem_addr  = r_addr;
                o_mem_wdata = w_merged;
            end
            c_ST_WRITE: begin
                o_mem_write = i_reset;
                o_mem_addr  = r_addr;
                o_mem_wdata = r_wdata;
            end
            c_ST_RESP: o_valid = i_reset;
            default: ;
        endcase
    end

    // Request latch and registered response
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_funct3   <= '0;
            r_is_store <= 1'b0;
            r_rdata    <= '0;
            r_fault    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr     <= i_addr;
                r_wdata    <= i_wdata;
                r_funct3   <= i_funct3;
                r_is_store <= i_is_store;
                if (w_req_fault) begin
                    r_rdata <= '0;
                    r_fault <= 1'b1;
                end
            end
            case (r_state)
                c_ST_EXTRACT: begin
                    r_rdata <= w_load_data;
                    r_fault <= 1'b0;
                end
                c_ST_MERGE, c_ST_WRITE: begin
                    r_rdata <= '0;
                    r_fault <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_rdata = r_rdata;
    assign o_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module       : tb_load_store_unit
// Description  : Self-checking bench for load_store_unit. A request-level
//                model predicts every cycle of handshake, strobes and
//                response; a word-array memory answers the DUT.
// Revision     : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int W = 32;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         i_reset;
    logic         i_valid;
    logic         o_ready;
    logic         i_is_store;
    logic [2:0]   i_funct3;
    logic [D-1:0] i_addr;
    logic [W-1:0] i_wdata;
    logic         o_valid;
    logic [W-1:0] o_rdata;
    logic         o_fault;
    logic [D-1:0] o_mem_addr;
    logic [W-1:0] o_mem_wdata;
    logic         o_mem_read;
    logic         o_mem_write;
    logic [W-1:0] i_mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.W(W), .D(D)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_is_store  (i_is_store),
        .i_funct3    (i_funct3),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_valid     (o_valid),
        .o_rdata     (o_rdata),
        .o_fault     (o_fault),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_read  (o_mem_read),
        .o_mem_write (o_mem_write),
        .i_mem_rdata (i_mem_rdata)
    );

    // ------------------------------------------------------------------
    // Synchronous word memory (DUT side) with a preload port
    // ------------------------------------------------------------------
    logic [31:0] mem [64];
    logic        ld_en  = 1'b0;
    logic [5:0]  ld_idx = '0;
    logic [31:0] ld_val = '0;

    always @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_val;
        if (o_mem_read) i_mem_rdata <= mem[o_mem_addr[7:2]];
        if (o_mem_write) mem[o_mem_addr[7:2]] <= o_mem_wdata;
    end

    // ------------------------------------------------------------------
    // Reference model state and per-cycle expectations
    // ------------------------------------------------------------------
    logic [31:0] ref_mem [64];
    logic [31:0] m_rdata;
    logic        m_fault;

    typedef struct {
        bit          rdy;
        bit          rd;
        bit          wr;
        bit          vld;
        bit          chk_bus;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          fault;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    function automatic exp_t mk(input string nm, input bit rdy, input bit rd, input bit wr,
                                input bit vld, input logic [7:0] a, input logic [31:0] wd);
        exp_t e;
        e.name    = nm;
        e.rdy     = rdy;
        e.rd      = rd;
        e.wr      = wr;
        e.vld     = vld;
        e.chk_bus = 1'b1;
        e.addr    = a;
        e.wdata   = wd;
        e.rdata   = m_rdata;
        e.fault   = m_fault;
        return e;
    endfunction

    // Legal-set membership plus natural alignment to 1/2/4 bytes
    function automatic bit m_is_fault(input bit st, input logic [2:0] f3, input logic [7:0] a);
        int size;
        bit legal;
        if (st) legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
        else    legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        size = 1 << f3[1:0];
        return !legal || ((int'(a) % size) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] lo);
        logic [31:0] v;
        v = word >> (8 * lo);
        case (f3)
            3'd0: return (v[7]  ? 32'hFFFF_FF00 : 32'h0) | (v & 32'hFF);
            3'd1: return (v[15] ? 32'hFFFF_0000 : 32'h0) | (v & 32'hFFFF);
            3'd2: return word;
            3'd4: return v & 32'hFF;
            3'd5: return v & 32'hFFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] word, input logic [2:0] f3,
                                            input logic [1:0] lo, input logic [31:0] wd);
        logic [31:0] mask;
        mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << (8 * lo);
        return (word & ~mask) | ((wd << (8 * lo)) & mask);
    endfunction

    // Compare process: one expectation per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, " ready"},  32'(o_ready),     32'(e.rdy));
            check({e.name, " read"},   32'(o_mem_read),  32'(e.rd));
            check({e.name, " write"},  32'(o_mem_write), 32'(e.wr));
            check({e.name, " valid"},  32'(o_valid),     32'(e.vld));
            check({e.name, " rdata"},  o_rdata,          e.rdata);
            check({e.name, " fault"},  32'(o_fault),     32'(e.fault));
            if (e.chk_bus) check({e.name, " addr"}, 32'(o_mem_addr), 32'(e.addr));
            if (e.chk_bus && e.wr) check({e.name, " wdata"}, o_mem_wdata, e.wdata);
        end
    end

    // One complete request; returns #1 after entering the response cycle
    task automatic req(input string nm, input bit st, input logic [2:0] f3,
                       input logic [7:0] a, input logic [31:0] wd);
        int          lat;
        bit          flt;
        logic [31:0] word;
        logic [31:0] mg;
        flt  = m_is_fault(st, f3, a);
        word = ref_mem[a[7:2]];
        @(posedge clk); #1;
        i_valid = 1'b1; i_is_store = st; i_funct3 = f3; i_addr = a; i_wdata = wd;
        exp_q.push_back(mk({nm, "/c0"}, 1, 0, 0, 0, 8'h00, 32'h0));
        if (flt) begin
            lat = 1;
            m_rdata = 32'h0; m_fault = 1'b1;
            exp_q.push_back(mk({nm, "/c1"}, 0, 0, 0, 1, 8'h00, 32'h0));
        end else if (st && f3 == 3'd2) begin
            lat = 2;
            exp_q.push_back(mk({nm, "/c1"}, 0, 0, 1, 0, a, wd));
            ref_mem[a[7:2]] = wd;
            m_rdata = 32'h0; m_fault = 1'b0;
            exp_q.push_back(mk({nm, "/c2"}, 0, 0, 0, 1, 8'h00, 32'h0));
        end else if (st) begin
            lat = 3;
            mg  = m_merge(word, f3, a[1:0], wd);
            exp_q.push_back(mk({nm, "/c1"}, 0, 1, 0, 0, a, 32'h0));
            exp_q.push_back(mk({nm, "/c2"}, 0, 0, 1, 0, a, mg));
            ref_mem[a[7:2]] = mg;
            m_rdata = 32'h0; m_fault = 1'b0;
            exp_q.push_back(mk({nm, "/c3"}, 0, 0, 0, 1, 8'h00, 32'h0));
        end else begin
            lat = 3;
            exp_q.push_back(mk({nm, "/c1"}, 0, 1, 0, 0, a, 32'h0));
            exp_q.push_back(mk({nm, "/c2"}, 0, 0, 0, 0, 8'h00, 32'h0));
            m_rdata = m_load(word, f3, a[1:0]); m_fault = 1'b0;
            exp_q.push_back(mk({nm, "/c3"}, 0, 0, 0, 1, 8'h00, 32'h0));
        end
        @(posedge clk); #1;
        // Scramble the request bus to prove the fields were latched
        i_valid = 1'b0; i_is_store = ~st; i_funct3 = 3'b111; i_addr = 8'hFF; i_wdata = 32'hFFFF_FFFF;
        repeat (lat - 1) @(posedge clk);
        #1;
    endtask

    initial begin
        i_reset = 1'b0; i_valid = 1'b0; i_is_store = 1'b0; i_funct3 = '0;
        i_addr = '0; i_wdata = '0;
        m_rdata = '0; m_fault = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;

        // Preload memory while in reset
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            ld_en = 1'b1; ld_idx = 6'(i); ld_val = (i == 4) ? 32'h8899_AABB : 32'h0;
        end
        ref_mem[4] = 32'h8899_AABB;
        @(posedge clk); #1;
        ld_en = 1'b0;
        // Reset state: held in reset, everything quiet
        exp_q.push_back(mk("reset", 0, 0, 0, 0, 8'h00, 32'h0));
        @(posedge clk); #1;
        i_reset = 1'b1;
        exp_q.push_back(mk("post_reset", 1, 0, 0, 0, 8'h00, 32'h0));

        // Loads with extension
        req("LB_11", 0, 3'd0, 8'h11, 32'h0);
        check("LB_11 lit rdata", o_rdata, 32'hFFFF_FFAA);
        check("LB_11 lit fault", 32'(o_fault), 32'h0);
        req("LHU_12", 0, 3'd5, 8'h12, 32'h0);
        check("LHU_12 lit rdata", o_rdata, 32'h0000_8899);
        req("LH_12", 0, 3'd1, 8'h12, 32'h0);
        check("LH_12 lit rdata", o_rdata, 32'hFFFF_8899);
        req("LW_10", 0, 3'd2, 8'h10, 32'h0);
        check("LW_10 lit rdata", o_rdata, 32'h8899_AABB);
        req("LBU_10", 0, 3'd4, 8'h10, 32'h0);
        check("LBU_10 lit rdata", o_rdata, 32'h0000_00BB);

        // Sub-word store, then read back
        req("SB_13", 1, 3'd0, 8'h13, 32'h1234_5655);
        check("SB_13 lit mem", mem[4], 32'h5599_AABB);
        req("LW_10b", 0, 3'd2, 8'h10, 32'h0);
        check("LW_10b lit rdata", o_rdata, 32'h5599_AABB);

        // Full-word store and upper-half store
        req("SW_14", 1, 3'd2, 8'h14, 32'hDEAD_BEEF);
        check("SW_14 lit mem", mem[5], 32'hDEAD_BEEF);
        req("SH_16", 1, 3'd1, 8'h16, 32'h0000_CAFE);
        req("LW_14", 0, 3'd2, 8'h14, 32'h0);
        check("LW_14 lit rdata", o_rdata, 32'hCAFE_BEEF);

        // Faults: misaligned and illegal funct3
        req("LW_12_flt", 0, 3'd2, 8'h12, 32'h0);
        check("LW_12 lit fault", 32'(o_fault), 32'h1);
        check("LW_12 lit rdata", o_rdata, 32'h0);
        req("SH_11_flt", 1, 3'd1, 8'h11, 32'h7777_7777);
        req("LD011_flt", 0, 3'd3, 8'h10, 32'h0);
        req("ST011_flt", 1, 3'd3, 8'h10, 32'h0);
        req("LH_13_flt", 0, 3'd1, 8'h13, 32'h0);
        req("LBU_after", 0, 3'd4, 8'h17, 32'h0);
        check("LBU_17 lit rdata", o_rdata, 32'h0000_00CA);
        check("faulted stores lit mem", mem[4], 32'h5599_AABB);

        // Reset asserted during MERGE of an SH: write must be dropped
        @(posedge clk); #1;
        i_valid = 1'b1; i_is_store = 1'b1; i_funct3 = 3'd1; i_addr = 8'h12; i_wdata = 32'h1111_CAFE;
        exp_q.push_back(mk("rst_sh/c0", 1, 0, 0, 0, 8'h00, 32'h0));
        @(posedge clk); #1;
        i_valid = 1'b0;
        exp_q.push_back(mk("rst_sh/c1", 0, 1, 0, 0, 8'h12, 32'h0));
        @(posedge clk); #1;
        i_reset = 1'b0;
        begin
            exp_t e;
            e = mk("rst_sh/c2", 0, 0, 0, 0, 8'h00, 32'h0);
            e.chk_bus = 1'b0;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        i_reset = 1'b1;
        m_rdata = 32'h0; m_fault = 1'b0;
        exp_q.push_back(mk("rst_sh/c3", 1, 0, 0, 0, 8'h00, 32'h0));
        @(posedge clk); #1;
        exp_q.push_back(mk("rst_sh/c4", 1, 0, 0, 0, 8'h00, 32'h0));
        check("rst_sh mem unchanged", mem[4], ref_mem[4]);
        check("rst_sh lit mem", mem[4], 32'h5599_AABB);

        req("LW_10c", 0, 3'd2, 8'h10, 32'h0);
        check("LW_10c lit rdata", o_rdata, 32'h5599_AABB);

        @(posedge clk); #1;
        @(posedge clk); #1;
        check("expectations drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
